video_pll_lock_sequencer: RTL and testbench



---
 rtl/video_pll_lock_sequencer.sv | 149 ++++++++++++++
 tb/tb_video_pll_lock_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/video_pll_lock_sequencer.sv
// ============================================================================
// Module   : video_pll_lock_sequencer
// Purpose  : Resets the video PLL, qualifies its lock and releases a clean
//            reset to the video-clock logic. Re-sequences on loss or timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module video_pll_lock_sequencer #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned CNT_W               = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             sw_pll_reset,
  output logic             pll_rst,
  output logic             video_rst,
  output logic             pll_ready,
  output logic [CNT_W-1:0] lock_loss_count,
  output logic [CNT_W-1:0] retry_count
);

  localparam int unsigned MAX_A   = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                    PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned TMR_W   = $clog2(MAX_CYC + 1);

  localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  localparam logic [1:0] S_PLL_RESET = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_QUALIFY   = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] loss_q, loss_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic             pll_rst_q, pll_rst_d;
  logic             video_rst_q, video_rst_d;
  logic             pll_ready_q, pll_ready_d;
  logic             locked_s;

  assign locked_s = sync2_q;

  // State register, synchronizer and all registered outputs.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PLL_RESET;
      timer_q     <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      loss_q      <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      video_rst_q <= 1'b1;
      pll_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      sync1_q     <= pll_locked;
      sync2_q     <= sync1_q;
      loss_q      <= loss_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      video_rst_q <= video_rst_d;
      pll_ready_q <= pll_ready_d;
    end
  end

  // Next-state logic; the software request overrides every transition and
  // suppresses any coincident counter increment.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    loss_d  = loss_q;
    retry_d = retry_q;
    if (sw_pll_reset) begin
      state_d = S_PLL_RESET;
      timer_d = '0;
    end else begin
      case (state_q)
        S_PLL_RESET: begin
          if (timer_q >= RST_LAST) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_ONE;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = (LOCK_STABLE_CYCLES <= 1) ? S_RUN : S_QUALIFY;
            timer_d = TMR_ONE;
          end else if (timer_q >= TIMEOUT_LAST) begin
            state_d = S_PLL_RESET;
            timer_d = '0;
            if (retry_q != CNT_MAX) retry_d = retry_q + 1'b1;
          end else begin
            timer_d = timer_q + TMR_ONE;
          end
        end
        S_QUALIFY: begin
          // timer_q holds the count of stable samples already seen
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
          end else if (timer_q >= STABLE_LAST) begin
            state_d = S_RUN;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TMR_ONE;
          end
        end
        default: begin
          if (!locked_s) begin
            state_d = S_WAIT_LOCK;
            timer_d = '0;
            if (loss_q != CNT_MAX) loss_d = loss_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the transition edge.
  always_comb begin
    pll_rst_d   = (state_d == S_PLL_RESET);
    video_rst_d = (state_d != S_RUN);
    pll_ready_d = (state_d == S_RUN);
  end

  assign pll_rst         = pll_rst_q;
  assign video_rst       = video_rst_q;
  assign pll_ready       = pll_ready_q;
  assign lock_loss_count = loss_q;
  assign retry_count     = retry_q;

endmodule

`default_nettype wire

// File: tb/tb_video_pll_lock_sequencer.sv
// ============================================================================
// Module   : tb_video_pll_lock_sequencer
// Purpose  : Directed bench for video_pll_lock_sequencer (4/8/32, CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_video_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sw_pll_reset = 1'b0;
  logic       pll_rst;
  logic       video_rst;
  logic       pll_ready;
  logic [1:0] lock_loss_count;
  logic [1:0] retry_count;

  int vectors = 0;
  int miscompares = 0;

  video_pll_lock_sequencer #(
    .PLL_RST_CYCLES     (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .CNT_W              (2)
  ) dut (
    .refclk         (refclk),
    .rst            (rst),
    .pll_locked     (pll_locked),
    .sw_pll_reset   (sw_pll_reset),
    .pll_rst        (pll_rst),
    .video_rst      (video_rst),
    .pll_ready      (pll_ready),
    .lock_loss_count(lock_loss_count),
    .retry_count    (retry_count)
  );

  always #5 refclk = ~refclk;

  // Advance n rising edges, then park on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Release reset and lock the PLL two cycles after pll_rst falls.
  task automatic release_and_lock(input string pfx);
    rst = 1'b0;
    cyc(3);
    chk({pfx, "_pll_rst_r3"}, {7'd0, pll_rst}, 8'd1);
    cyc(1);
    chk({pfx, "_pll_rst_r4"}, {7'd0, pll_rst}, 8'd0);
    chk({pfx, "_vrst_r4"}, {7'd0, video_rst}, 8'd1);
    cyc(1);
    pll_locked = 1'b1;
    cyc(9);
    chk({pfx, "_vrst_e8"}, {7'd0, video_rst}, 8'd1);
    chk({pfx, "_ready_e8"}, {7'd0, pll_ready}, 8'd0);
    cyc(1);
    chk({pfx, "_vrst_e9"}, {7'd0, video_rst}, 8'd0);
    chk({pfx, "_ready_e9"}, {7'd0, pll_ready}, 8'd1);
    chk({pfx, "_loss_e9"}, {6'd0, lock_loss_count}, 8'd0);
    chk({pfx, "_retry_e9"}, {6'd0, retry_count}, 8'd0);
  endtask

  initial begin
    // Reset state
    cyc(3);
    chk("rst_pll_rst", {7'd0, pll_rst}, 8'd1);
    chk("rst_vrst", {7'd0, video_rst}, 8'd1);
    chk("rst_ready", {7'd0, pll_ready}, 8'd0);
    chk("rst_loss", {6'd0, lock_loss_count}, 8'd0);
    chk("rst_retry", {6'd0, retry_count}, 8'd0);

    // Scenario 1: power-up sequence
    release_and_lock("s1");

    // Scenario 2: one-cycle lock drop in RUN
    pll_locked = 1'b0;
    cyc(1);
    pll_locked = 1'b1;
    cyc(1);
    chk("s2_vrst_f2", {7'd0, video_rst}, 8'd0);
    cyc(1);
    chk("s2_vrst_f3", {7'd0, video_rst}, 8'd1);
    chk("s2_ready_f3", {7'd0, pll_ready}, 8'd0);
    chk("s2_loss_f3", {6'd0, lock_loss_count}, 8'd1);
    chk("s2_pll_rst_f3", {7'd0, pll_rst}, 8'd0);
    cyc(7);
    chk("s2_vrst_relock7", {7'd0, video_rst}, 8'd1);
    cyc(1);
    chk("s2_vrst_relock8", {7'd0, video_rst}, 8'd0);
    chk("s2_ready_relock8", {7'd0, pll_ready}, 8'd1);

    // Scenario 4: software re-sequence, then glitch during QUALIFY
    sw_pll_reset = 1'b1;
    cyc(1);
    sw_pll_reset = 1'b0;
    chk("s4_sw_pll_rst", {7'd0, pll_rst}, 8'd1);
    chk("s4_sw_vrst", {7'd0, video_rst}, 8'd1);
    chk("s4_sw_loss", {6'd0, lock_loss_count}, 8'd1);
    cyc(3);
    chk("s4_pll_rst_g4", {7'd0, pll_rst}, 8'd1);
    cyc(1);
    chk("s4_pll_rst_g5", {7'd0, pll_rst}, 8'd0);
    cyc(3);
    pll_locked = 1'b0;
    cyc(1);
    pll_locked = 1'b1;
    cyc(2);
    chk("s4_vrst_glitch", {7'd0, video_rst}, 8'd1);
    cyc(7);
    chk("s4_vrst_seven", {7'd0, video_rst}, 8'd1);
    cyc(1);
    chk("s4_vrst_eight", {7'd0, video_rst}, 8'd0);
    chk("s4_loss_kept", {6'd0, lock_loss_count}, 8'd1);

    // Scenario 5: sw request coincides with lock loss in RUN
    pll_locked = 1'b0;
    cyc(2);
    sw_pll_reset = 1'b1;
    cyc(1);
    sw_pll_reset = 1'b0;
    chk("s5_pll_rst", {7'd0, pll_rst}, 8'd1);
    chk("s5_vrst", {7'd0, video_rst}, 8'd1);
    chk("s5_ready", {7'd0, pll_ready}, 8'd0);
    chk("s5_loss", {6'd0, lock_loss_count}, 8'd1);

    // Scenario 3: lock never arrives, timeout retries saturate at 3
    cyc(3);
    chk("s3_pll_rst_h6", {7'd0, pll_rst}, 8'd1);
    cyc(1);
    chk("s3_pll_rst_h7", {7'd0, pll_rst}, 8'd0);
    cyc(31);
    chk("s3_pll_rst_h38", {7'd0, pll_rst}, 8'd0);
    chk("s3_retry_h38", {6'd0, retry_count}, 8'd0);
    cyc(1);
    chk("s3_pll_rst_h39", {7'd0, pll_rst}, 8'd1);
    chk("s3_retry_h39", {6'd0, retry_count}, 8'd1);
    cyc(3);
    chk("s3_pll_rst_h42", {7'd0, pll_rst}, 8'd1);
    cyc(1);
    chk("s3_pll_rst_h43", {7'd0, pll_rst}, 8'd0);
    cyc(31);
    chk("s3_retry_h74", {6'd0, retry_count}, 8'd1);
    cyc(1);
    chk("s3_pll_rst_h75", {7'd0, pll_rst}, 8'd1);
    chk("s3_retry_h75", {6'd0, retry_count}, 8'd2);
    cyc(36);
    chk("s3_pll_rst_h111", {7'd0, pll_rst}, 8'd1);
    chk("s3_retry_h111", {6'd0, retry_count}, 8'd3);
    cyc(35);
    chk("s3_pll_rst_h146", {7'd0, pll_rst}, 8'd0);
    cyc(1);
    chk("s3_pll_rst_h147", {7'd0, pll_rst}, 8'd1);
    chk("s3_retry_sat", {6'd0, retry_count}, 8'd3);
    chk("s3_vrst", {7'd0, video_rst}, 8'd1);

    // Scenario 6: asynchronous reset in the middle of QUALIFY
    pll_locked = 1'b1;
    cyc(6);
    chk("s6_in_qualify_pll_rst", {7'd0, pll_rst}, 8'd0);
    chk("s6_in_qualify_vrst", {7'd0, video_rst}, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("s6_async_pll_rst", {7'd0, pll_rst}, 8'd1);
    chk("s6_async_vrst", {7'd0, video_rst}, 8'd1);
    chk("s6_async_ready", {7'd0, pll_ready}, 8'd0);
    chk("s6_async_loss", {6'd0, lock_loss_count}, 8'd0);
    chk("s6_async_retry", {6'd0, retry_count}, 8'd0);
    pll_locked = 1'b0;
    @(negedge refclk);
    release_and_lock("s6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
